// File: rtl/cart_loader_pkg.sv
// cart_loader_pkg: shared types and constants for the cartridge loader
package cart_loader_pkg;
    typedef enum logic [1:0] {HOLD, RUN, LOAD, FLUSH} state_t;
    localparam int CART_AW = 15;
    localparam int CART_MAX = 32768;
    localparam int SIZE_W = $clog2(CART_MAX) + 1;
    localparam logic [7:0] OPEN_BUS = 8'hFF;
endpackage

// File: rtl/cart_loader_if.sv
// cart_loader_if: HPS download, console cart read, cart RAM and status signals
interface cart_loader_if;
    import cart_loader_pkg::*;
    logic                ioctl_download;
    logic [7:0]          ioctl_index;
    logic                ioctl_wr;
    logic [24:0]         ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic                ioctl_wait;
    logic [CART_AW-1:0]  cpu_a;
    logic                cpu_rd;
    logic [7:0]          cpu_d;
    logic                cpu_ack;
    logic [CART_AW-1:0]  mem_a;
    logic                mem_we;
    logic [7:0]          mem_d;
    logic [7:0]          mem_q;
    logic [SIZE_W-1:0]   cart_size;
    logic [CART_AW-1:0]  cart_mask;
    logic                load_err;
    logic                console_reset;
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, cpu_a, cpu_rd, mem_q,
        output ioctl_wait, cpu_d, cpu_ack, mem_a, mem_we, mem_d, cart_size, cart_mask, load_err, console_reset
    );
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, cpu_a, cpu_rd, mem_q,
        input  ioctl_wait, cpu_d, cpu_ack, mem_a, mem_we, mem_d, cart_size, cart_mask, load_err, console_reset
    );
endinterface

// File: rtl/cart_mask_gen.sv
// cart_mask_gen: mirror mask = next power of two >= size, minus one (0 for empty cart)
module cart_mask_gen
    import cart_loader_pkg::*;
(
    input  logic [SIZE_W-1:0]  size,
    output logic [CART_AW-1:0] mask
);
    logic [CART_AW-1:0] s, m1, m2, m3, m4;
    assign s    = CART_AW'(size - SIZE_W'(1));
    assign m1   = s  | (s  >> 1);
    assign m2   = m1 | (m1 >> 2);
    assign m3   = m2 | (m2 >> 4);
    assign m4   = m3 | (m3 >> 8);
    assign mask = size == '0 ? '0 : m4;
endmodule

// File: rtl/cart_loader.sv
// cart_loader: loads a cartridge image from the HPS into cart RAM and serves console reads
module cart_loader
    import cart_loader_pkg::*;
#(
    parameter logic [7:0] CART_IDX = 8'd1,
    parameter int         RST_HOLD = 16
)(
    input  logic clk_sys,
    input  logic reset,
    cart_loader_if.slave bus
);
    state_t             state;
    logic [15:0]        cnt;
    logic [CART_AW-1:0] mask_next;
    logic [SIZE_W-1:0]  addr_end;
    logic               dl, wr_ok, wr_in, wr_bad, rd_mem, to_load;
    logic               p1, p1m, p2, p2m;

    assign dl       = bus.ioctl_download && bus.ioctl_index == CART_IDX;
    assign wr_ok    = state == LOAD && bus.ioctl_wr && !bus.ioctl_wait;
    assign wr_in    = wr_ok && bus.ioctl_addr[24:CART_AW] == '0;
    assign wr_bad   = wr_ok && bus.ioctl_addr[24:CART_AW] != '0;
    assign rd_mem   = bus.cpu_rd && state == RUN && bus.cart_size != '0;
    assign to_load  = dl && (state == RUN || state == HOLD);
    assign addr_end = SIZE_W'(bus.ioctl_addr[CART_AW-1:0]) + SIZE_W'(1);

    cart_mask_gen u_mask (
        .size (bus.cart_size),
        .mask (mask_next)
    );

    // Control FSM, download write path and the shared RAM address port
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state             <= HOLD;
            cnt               <= 16'(RST_HOLD);
            bus.console_reset <= 1'b1;
            bus.cart_size     <= '0;
            bus.cart_mask     <= '0;
            bus.load_err      <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_a         <= '0;
            bus.mem_d         <= '0;
            bus.ioctl_wait    <= 1'b0;
        end else begin
            bus.mem_we     <= wr_in;
            bus.ioctl_wait <= (p1m || rd_mem) && (state == LOAD || to_load);
            if (wr_in) begin
                bus.mem_a <= bus.ioctl_addr[CART_AW-1:0];
                bus.mem_d <= bus.ioctl_dout;
                if (addr_end > bus.cart_size)
                    bus.cart_size <= addr_end;
            end else if (bus.cpu_rd && state == RUN)
                bus.mem_a <= bus.cpu_a & bus.cart_mask;
            if (wr_bad)
                bus.load_err <= 1'b1;
            case (state)
                HOLD, RUN: begin
                    if (dl) begin
                        state             <= LOAD;
                        bus.console_reset <= 1'b1;
                        bus.cart_size     <= '0;
                        bus.load_err      <= 1'b0;
                    end else if (state == HOLD) begin
                        cnt <= cnt - 16'd1;
                        if (cnt <= 16'd1) begin
                            state             <= RUN;
                            bus.console_reset <= 1'b0;
                        end
                    end
                end
                LOAD: if (!dl) state <= FLUSH;
                FLUSH: begin
                    bus.cart_mask <= mask_next;
                    cnt           <= 16'(RST_HOLD);
                    state         <= HOLD;
                end
            endcase
        end
    end

    // Two-stage read pipeline; only RUN reads of a loaded cart return RAM data
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            p1          <= 1'b0;
            p1m         <= 1'b0;
            p2          <= 1'b0;
            p2m         <= 1'b0;
            bus.cpu_ack <= 1'b0;
            bus.cpu_d   <= OPEN_BUS;
        end else begin
            p1          <= bus.cpu_rd;
            p1m         <= rd_mem;
            p2          <= p1;
            p2m         <= p1m;
            bus.cpu_ack <= p2;
            if (p2)
                bus.cpu_d <= p2m ? bus.mem_q : OPEN_BUS;
        end
    end
endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: randomized scoreboard bench for cart_loader
module tb_cart_loader;
    typedef struct { logic [7:0] d; int c; } rd_t;
    typedef struct { logic [14:0] a; logic [7:0] d; } wr_t;

    logic clk_sys = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    rd_t rq[$];
    wr_t wq[$];
    logic [7:0] ram [32768];
    logic [7:0] model_mem [32768];
    int msize = 0;
    int mmask = 0;
    bit merr = 0;

    cart_loader_if bus();

    cart_loader #(.CART_IDX(8'd1), .RST_HOLD(16)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc++;

    always @(posedge clk_sys) begin
        if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
        bus.mem_q <= ram[bus.mem_a];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ref_mask(input int size);
        int p = 1;
        if (size == 0) return 0;
        while (p < size) p = p * 2;
        return p - 1;
    endfunction

    function automatic logic [7:0] mem_exp(input logic [14:0] a);
        return msize == 0 ? 8'hFF : model_mem[int'(a) & mmask];
    endfunction

    // read monitor: every ack must match the oldest outstanding read in data and timing
    always @(negedge clk_sys) begin
        rd_t e;
        if (bus.cpu_ack) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected_ack: got ack with d=%0h want no ack (cycle %0d)", bus.cpu_d, cyc);
            end else begin
                e = rq.pop_front();
                chk("rd_data", bus.cpu_d, e.d);
                chk("rd_cycle", cyc, e.c);
            end
        end else if (rq.size() != 0 && cyc > rq[0].c) begin
            e = rq.pop_front();
            total++; bad++;
            $display("FAIL rd_missing_ack: got none by cycle %0d want ack at %0d", cyc, e.c);
        end
    end

    // write monitor: every RAM write must be an expected accepted download byte
    always @(negedge clk_sys) begin
        wr_t w;
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_unexpected: got mem_we a=%0h d=%0h want none (cycle %0d)", bus.mem_a, bus.mem_d, cyc);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", bus.mem_a, w.a);
                chk("wr_data", bus.mem_d, w.d);
            end
        end
    end

    task automatic rd(input logic [14:0] a, input logic [7:0] d);
        bus.cpu_rd = 1'b1;
        bus.cpu_a = a;
        rq.push_back('{d: d, c: cyc + 3});
        @(negedge clk_sys);
        bus.cpu_rd = 1'b0;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        int b = 0;
        while (bus.ioctl_wait && b < 50) begin
            @(negedge clk_sys);
            b++;
        end
        if (b == 50) begin
            total++; bad++;
            $display("FAIL wr_wait_timeout: got ioctl_wait stuck want release (cycle %0d)", cyc);
        end
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        if (a[24:15] == 10'd0) begin
            wq.push_back('{a: a[14:0], d: d});
            model_mem[a[14:0]] = d;
            if (int'(a[14:0]) + 1 > msize) msize = int'(a[14:0]) + 1;
        end else
            merr = 1;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic wait_run(input string nm, input int exp_n);
        int n = 0;
        while (n < 300) begin
            @(negedge clk_sys);
            n++;
            if (!bus.console_reset) break;
        end
        chk(nm, n, exp_n);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_download = 1'b1;
        bus.ioctl_index = idx;
        if (idx == 8'd1) begin
            msize = 0;
            merr = 0;
        end
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        mmask = ref_mask(msize);
        wait_run("hold_after_download", 18);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_size"}, bus.cart_size, msize);
        chk({tag, "_mask"}, bus.cart_mask, mmask);
        chk({tag, "_err"}, bus.load_err, merr);
    endtask

    task automatic rand_reads(input int n, input int lim);
        logic [14:0] a;
        for (int i = 0; i < n; i++) begin
            a = 15'($urandom_range(0, lim - 1)) | (15'($urandom_range(0, 1)) << 14);
            rd(a, mem_exp(a));
        end
    endtask

    initial begin
        bit cr_seen;
        bus.ioctl_download = 0; bus.ioctl_index = 0; bus.ioctl_wr = 0;
        bus.ioctl_addr = 0; bus.ioctl_dout = 0; bus.cpu_a = 0; bus.cpu_rd = 0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("rst_console_reset", bus.console_reset, 1);
        chk("rst_cart_size", bus.cart_size, 0);
        chk("rst_cart_mask", bus.cart_mask, 0);
        chk("rst_load_err", bus.load_err, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_cpu_ack", bus.cpu_ack, 0);
        chk("rst_cpu_d", bus.cpu_d, 8'hFF);
        chk("rst_ioctl_wait", bus.ioctl_wait, 0);
        reset = 1'b0;
        wait_run("hold_after_reset", 16);
        rd(15'h0000, 8'hFF);
        rand_reads(6, 32768);
        repeat (4) @(negedge clk_sys);

        start_dl(8'd1);
        @(negedge clk_sys);
        for (int a = 0; a < 8192; a++) begin
            wr_byte(25'(a), 8'(a));
            if (a == 4000) chk("load_console_reset", bus.console_reset, 1);
        end
        end_dl();
        check_status("dl8k");
        rd(15'h2005, 8'h05);
        rand_reads(24, 8192);
        repeat (4) @(negedge clk_sys);

        start_dl(8'd1);
        @(negedge clk_sys);
        for (int a = 0; a < 12000; a++) begin
            wr_byte(25'(a), 8'($urandom));
            if (a == 5000) begin
                rd(15'h0010, 8'hFF);
                rd(15'h1234, 8'hFF);
                rd(15'h7FFF, 8'hFF);
            end
        end
        wr_byte(25'h8000, 8'hAA);
        chk("bad_addr_load_err", bus.load_err, 1);
        end_dl();
        check_status("dl12k");
        rand_reads(24, 12000);
        repeat (4) @(negedge clk_sys);

        rd(15'h0123, mem_exp(15'h0123));
        start_dl(8'd1);
        @(negedge clk_sys);
        chk("inflight_wait_high", bus.ioctl_wait, 1);
        @(negedge clk_sys);
        chk("inflight_wait_low", bus.ioctl_wait, 0);
        for (int a = 0; a < 300; a++) wr_byte(25'(a), 8'($urandom));
        end_dl();
        check_status("dl300");
        rand_reads(16, 512);
        repeat (4) @(negedge clk_sys);

        start_dl(8'd1);
        @(negedge clk_sys);
        for (int a = 0; a < 100; a++) wr_byte(25'(a), 8'($urandom));
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = 25'd100;
        bus.ioctl_dout = 8'h5A;
        @(posedge clk_sys);
        #1;
        reset = 1'b1;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        msize = 0; mmask = 0; merr = 0;
        @(negedge clk_sys);
        chk("abort_mem_we", bus.mem_we, 0);
        chk("abort_console_reset", bus.console_reset, 1);
        check_status("abort");
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        wait_run("hold_after_abort", 16);
        check_status("after_abort");
        rand_reads(8, 32768);
        repeat (4) @(negedge clk_sys);

        start_dl(8'd0);
        cr_seen = 0;
        for (int i = 0; i < 8; i++) begin
            bus.ioctl_wr = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'h77;
            @(negedge clk_sys);
            cr_seen |= bus.console_reset;
        end
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        repeat (3) begin
            @(negedge clk_sys);
            cr_seen |= bus.console_reset;
        end
        chk("idx0_console_reset", cr_seen, 0);
        check_status("idx0");
        rand_reads(6, 32768);

        repeat (6) @(negedge clk_sys);
        chk("rd_queue_drained", rq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
